// File: rtl/bss_if.sv
// bss_if: handshake and operand/result bundle for the bit-serial subtractor.
//   master : drives start, a, b; observes diff, bout, ovf, busy, done
//   slave  : the subtractor side (bss)
interface bss_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             busy;
    logic             done;

    modport master (output start, a, b, input diff, bout, ovf, busy, done);
    modport slave  (input start, a, b, output diff, bout, ovf, busy, done);
endinterface

// File: rtl/bss.sv
// bss: bit-serial subtractor, a - b computed LSB first through one
// full-subtractor cell and a registered borrow.
//   clk  : clock, all state changes on posedge
//   clr  : synchronous active-high clear
//   bus  : bss_if.slave -- start/a/b in; diff/bout/ovf/busy/done out
// An operation is accepted in IDLE or DONE, takes WIDTH SHIFT cycles, and
// the registered result plus a one-cycle done appear in the following cycle.
module bss #(
    parameter int WIDTH = 8
) (
    input  logic  clk,
    input  logic  clr,
    bss_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sa, sb, res;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             a_msb, b_msb;   // sign bits survive the operand shift

    logic d, br_nxt, accept, last;

    // full-subtractor cell on the current LSBs
    assign d      = sa[0] ^ sb[0] ^ br;
    assign br_nxt = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    assign accept = bus.start && (state == IDLE || state == DONE);
    assign last   = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= IDLE;
            sa       <= '0;
            sb       <= '0;
            res      <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            bus.diff <= '0;
            bus.bout <= 1'b0;
            bus.ovf  <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else if (accept) begin
            // DONE + start reloads directly: back-to-back with no bubble
            sa       <= bus.a;
            sb       <= bus.b;
            br       <= 1'b0;
            cnt      <= '0;
            a_msb    <= bus.a[WIDTH-1];
            b_msb    <= bus.b[WIDTH-1];
            state    <= SHIFT;
            bus.busy <= 1'b1;
            bus.done <= 1'b0;
        end else begin
            case (state)
                SHIFT: begin
                    res <= {d, res[WIDTH-1:1]};
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    br  <= br_nxt;
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        bus.diff <= {d, res[WIDTH-1:1]};
                        bus.bout <= br_nxt;
                        // overflow only when signs differ and result sign
                        // departs from the minuend's
                        bus.ovf  <= (a_msb != b_msb) && (d != a_msb);
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bss.sv
// tb_bss: self-checking bench for bss. A timestamp-based reference model
// predicts busy/done and computes results with plain integer arithmetic;
// a negedge compare process checks every cycle, and directed cases pin
// literal expectations.
module tb_bss;
    localparam int W = 8;

    logic clk = 1'b0;
    logic clr = 1'b1;
    bss_if #(.WIDTH(W)) bus();

    bss #(.WIDTH(W)) dut (.clk(clk), .clr(clr), .bus(bus));

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int  cyc = 0;
    int  m_end;
    bit  m_busy = 0, m_done = 0, m_bout = 0, m_ovf = 0;
    int  m_diff = 0;
    int  p_diff, p_bout, p_ovf;
    bit  chk_en = 0;

    always @(posedge clk) begin
        int sa, sb, t;
        cyc++;
        if (clr) begin
            m_busy = 0; m_done = 0; m_diff = 0; m_bout = 0; m_ovf = 0;
        end else begin
            m_done = 0;
            if (m_busy && cyc == m_end) begin
                m_busy = 0; m_done = 1;
                m_diff = p_diff; m_bout = p_bout[0]; m_ovf = p_ovf[0];
            end else if (!m_busy && bus.start) begin
                m_busy = 1;
                m_end  = cyc + W;
                sa = int'(bus.a); sb = int'(bus.b);
                p_diff = (sa - sb) & ((1 << W) - 1);
                p_bout = (sa < sb) ? 1 : 0;
                if (sa >= (1 << (W-1))) sa -= (1 << W);
                if (sb >= (1 << (W-1))) sb -= (1 << W);
                t = sa - sb;
                p_ovf = (t > (1 << (W-1)) - 1 || t < -(1 << (W-1))) ? 1 : 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", int'(bus.busy), int'(m_busy));
            chk("done", int'(bus.done), int'(m_done));
            chk("diff", int'(bus.diff), m_diff);
            chk("bout", int'(bus.bout), int'(m_bout));
            chk("ovf",  int'(bus.ovf),  int'(m_ovf));
            if (bus.busy && bus.done) chk("busy_and_done", 1, 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_done(output int n, output int nbusy);
        n = 0; nbusy = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (bus.busy) nbusy++;
            if (bus.done) break;
            if (n > 40) begin
                chk("done_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic launch(input int a, input int b);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.a = W'(a); bus.b = W'(b);
        @(posedge clk); #1;
        bus.start = 1'b0; bus.a = W'($urandom); bus.b = W'($urandom);
    endtask

    task automatic run_op(input int a, input int b, input int ed, input int eb, input int eo);
        int n, nb;
        launch(a, b);
        wait_done(n, nb);
        chk($sformatf("lit_diff_%0d_%0d", a, b), int'(bus.diff), ed);
        chk($sformatf("lit_bout_%0d_%0d", a, b), int'(bus.bout), eb);
        chk($sformatf("lit_ovf_%0d_%0d", a, b),  int'(bus.ovf),  eo);
    endtask

    initial begin
        int n, nb, ndone;
        bus.start = 1'b0; bus.a = '0; bus.b = '0;
        repeat (3) @(posedge clk);
        #1 clr = 1'b0;
        chk_en = 1;
        @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_diff", int'(bus.diff), 0);

        // first op: latency and busy length
        launch(100, 37);
        wait_done(n, nb);
        chk("lat_busy_cycles", nb, 8);
        chk("lat_done_at", n, 9);
        chk("lit_diff_100_37", int'(bus.diff), 63);
        chk("lit_bout_100_37", int'(bus.bout), 0);

        run_op(5, 10, 251, 1, 0);
        run_op(8'h80, 8'h01, 8'h7F, 0, 1);
        run_op(8'h7F, 8'hFF, 8'h80, 1, 1);
        run_op(0, 0, 0, 0, 0);
        run_op(255, 255, 0, 0, 0);
        run_op(0, 255, 1, 1, 0);

        // start during SHIFT is ignored
        launch(10, 3);
        @(posedge clk); @(posedge clk); #1;
        bus.start = 1'b1; bus.a = 8'd99; bus.b = 8'd1;
        @(posedge clk); #1 bus.start = 1'b0;
        wait_done(n, nb);
        chk("ignore_start_diff", int'(bus.diff), 7);

        // back-to-back through the done cycle
        launch(20, 5);
        wait_done(n, nb);
        chk("b2b_first_diff", int'(bus.diff), 15);
        bus.start = 1'b1; bus.a = 8'd200; bus.b = 8'd50;
        @(posedge clk); #1 bus.start = 1'b0;
        @(negedge clk);
        chk("b2b_busy_next", int'(bus.busy), 1);
        wait_done(n, nb);
        chk("b2b_gap", n + 1, 9);
        chk("b2b_diff", int'(bus.diff), 150);

        // clear mid-flight
        launch(50, 20);
        repeat (3) @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        @(negedge clk);
        chk("clr_busy", int'(bus.busy), 0);
        chk("clr_done", int'(bus.done), 0);
        chk("clr_diff", int'(bus.diff), 0);
        chk("clr_bout", int'(bus.bout), 0);
        chk("clr_ovf",  int'(bus.ovf),  0);
        ndone = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("clr_no_done", ndone, 0);
        run_op(9, 4, 5, 0, 0);

        // randomized traffic, model-checked every cycle
        repeat (3000) begin
            @(posedge clk); #1;
            bus.start = ($urandom_range(0, 2) == 0);
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
            clr       = ($urandom_range(0, 150) == 0);
        end
        #1 clr = 1'b0; bus.start = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bss.md
Name: bss

Overview:
- Bit-serial subtractor: the inverse-operation companion to the team's bit-serial adder.
- Accepts two parallel WIDTH-bit operands and computes a − b one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow.
- Returns the parallel difference, the final borrow and the signed overflow, with a start/busy/done handshake.
- Sits beside the serial adder in the datapath for area-constrained arithmetic.

Parameters:
WIDTH, 8, operand and result width in bits (≥2)

Ports:
clk  input  1  clock; all state changes on posedge
clr  input  1  synchronous active-high reset; clears all state on posedge clk
start  input  1  request; sampled only in IDLE or DONE
a  input  WIDTH  minuend; sampled on the accepting edge only
b  input  WIDTH  subtrahend; sampled on the accepting edge only
diff  output  WIDTH  registered result a − b mod 2^WIDTH; updated only on completion
bout  output  1  registered final borrow (1 when a < b unsigned)
ovf  output  1  registered signed overflow of a − b (two's complement)
busy  output  1  high while in SHIFT
done  output  1  one-cycle pulse in the cycle after the last bit is computed

Behaviour:
- Reset (clr=1 at posedge): state=IDLE. diff, bout, ovf, busy and done are all 0. Internal shift registers, borrow flop and bit counter are 0. clr overrides start and any in-flight operation. An operation aborted mid-flight produces no done and leaves diff at 0.
- States: IDLE, SHIFT, DONE.
- IDLE, start=1: load a into sa and b into sb, borrow=0, count=0, go to SHIFT. start=0 stays in IDLE.
- SHIFT, every cycle:
  - d = sa[0]^sb[0]^br
  - br_next = (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&br)
  - result shift register takes d at its MSB and shifts right; sa and sb shift right; br<=br_next; count<=count+1.
  - On the cycle with count==WIDTH−1, also:
    - diff <= {d, result[WIDTH−1:1]}
    - bout <= br_next
    - ovf <= (a_msb != b_msb) && (d != a_msb), where a_msb and b_msb are the original operand MSBs held in a capture register.
    - go to DONE.
  - start is ignored in SHIFT.
- DONE: done=1 for exactly this one cycle.
  - start=1: reload as from IDLE and go to SHIFT (back-to-back, no bubble).
  - start=0: go to IDLE.
- busy is 1 exactly in SHIFT. done and busy are never both high.
- Latency: accepting edge E0, bits computed on edges E1..EWIDTH, diff/bout/ovf valid and done high in the cycle after EWIDTH. Throughput is one result per WIDTH+1 cycles.
- Outputs hold their last completed value through IDLE and SHIFT until the next completion.
- a and b may change freely after the accepting edge.
- Counter width is clog2(WIDTH)+1. No arithmetic wrap is permitted in count.

Test Plan:
- 100 − 37 (WIDTH=8): start one cycle -> busy for 8 cycles, then done pulse; diff=63, bout=0, ovf=0.
- 5 − 10: diff=251 (0xFB), bout=1, ovf=0.
- 0x80 − 0x01: diff=0x7F, bout=0, ovf=1. Also 0x7F − 0xFF: diff=0x80, bout=1, ovf=1.
- Edge operands: 0−0 gives diff=0, bout=0. 255−255 gives diff=0, bout=0. 0−255 gives diff=1, bout=1.
- start re-asserted at cycle 3 of SHIFT with different a/b -> ignored; result matches the original operands. start held during the done cycle with 200−50 -> busy the next cycle, second done 9 cycles after the first, diff=150.
- clr asserted at cycle 4 of SHIFT -> next cycle busy=0, done=0, diff=0, bout=0, ovf=0, and no done pulse follows. A fresh start afterwards completes correctly.
